// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV64 instruction packer.
// S1 holds the decoded fields and range-checks the immediate; S2 is the
// output register presenting the packed word and its memory address.
module instr_encoder #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter logic [63:0] ADDR_STEP = 64'd4,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           imm_type,
  input  logic [63:0]          immediate,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [2:0]           funct3,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [6:0]           funct7,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instruction,
  output logic [63:0]          out_addr,
  output logic                 range_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] T_I = 3'b000;
  localparam logic [2:0] T_S = 3'b001;
  localparam logic [2:0] T_B = 3'b010;
  localparam logic [2:0] T_R = 3'b011;

  // vld_pipe[0] = S1 occupied, vld_pipe[1] = S2 occupied
  logic [1:0]  vld_pipe;
  logic [2:0]  s1_type;
  logic [63:0] s1_imm;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [2:0]  s1_f3;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [6:0]  s1_f7;

  logic        s1_ok;
  logic        s1_adv;
  logic        out_hs;
  logic [31:0] s1_word;

  assign out_valid = vld_pipe[1];
  assign s1_adv    = vld_pipe[0] && (!vld_pipe[1] || out_ready);
  assign in_ready  = !vld_pipe[0] || s1_adv;
  assign out_hs    = vld_pipe[1] && out_ready;

  // Immediate range check and packing, both from the S1 registers
  always_comb begin
    s1_ok   = 1'b0;
    s1_word = '0;
    case (s1_type)
      T_I: begin
        s1_ok   = (&s1_imm[63:11]) || !(|s1_imm[63:11]);
        s1_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
      end
      T_S: begin
        s1_ok   = (&s1_imm[63:11]) || !(|s1_imm[63:11]);
        s1_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
      end
      T_B: begin
        // branch offsets are 13-bit signed and halfword aligned
        s1_ok   = ((&s1_imm[63:12]) || !(|s1_imm[63:12])) && !s1_imm[0];
        s1_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                   s1_imm[4:1], s1_imm[11], s1_op};
      end
      T_R: begin
        s1_ok   = 1'b1;
        s1_word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
      end
      default: begin
        s1_ok   = 1'b0;
        s1_word = '0;
      end
    endcase
  end

  // S1: capture fields whenever the stage is free or draining this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[0] <= 1'b0;
    end else if (in_ready) begin
      vld_pipe[0] <= in_valid;
      if (in_valid) begin
        s1_type <= imm_type;
        s1_imm  <= immediate;
        s1_op   <= opcode;
        s1_rd   <= rd;
        s1_f3   <= funct3;
        s1_rs1  <= rs1;
        s1_rs2  <= rs2;
        s1_f7   <= funct7;
      end
    end
  end

  // S2: load ok entries, empty on handshake; failed entries never arrive
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      instruction <= '0;
    end else if (s1_adv && s1_ok) begin
      vld_pipe[1] <= 1'b1;
      instruction <= s1_word;
    end else if (out_hs) begin
      vld_pipe[1] <= 1'b0;
    end
  end

  // Address of the word in S2; moves only when a word leaves
  always_ff @(posedge clk) begin
    if (reset)       out_addr <= BASE_ADDR;
    else if (out_hs) out_addr <= out_addr + ADDR_STEP;
  end

  // Drop reporting: one-cycle pulse plus saturating counter
  always_ff @(posedge clk) begin
    if (reset) begin
      range_err <= 1'b0;
      err_count <= '0;
    end else begin
      range_err <= s1_adv && !s1_ok;
      if (s1_adv && !s1_ok && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with hand-computed instruction words.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_type;
  logic [63:0] immediate;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [63:0] out_addr;
  logic        range_err;
  logic [15:0] err_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .imm_type(imm_type), .immediate(immediate), .opcode(opcode), .rd(rd),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
    .out_addr(out_addr), .range_err(range_err), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [2:0] t, input logic [63:0] imm, input logic [6:0] op,
                     input logic [4:0] d, input logic [2:0] f3, input logic [4:0] a,
                     input logic [4:0] b, input logic [6:0] f7);
    in_valid  = 1'b1;
    imm_type  = t;
    immediate = imm;
    opcode    = op;
    rd        = d;
    funct3    = f3;
    rs1       = a;
    rs2       = b;
    funct7    = f7;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drv(3'b000, 64'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0);
    in_valid = 1'b0;

    // ---- reset state
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_addr", out_addr, 64'h0);
    chk("rst_err_count", err_count, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_instruction", instruction, 0);

    // ---- single I-type, latency 2
    drv(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 7'b0010011, 5'd5, 3'd0, 5'd6, 5'd0, 7'd0);
    step();
    in_valid = 1'b0;
    chk("i_lat1_valid", out_valid, 0);
    step();
    chk("i_valid", out_valid, 1);
    chk("i_word", instruction, 32'hFFF30293);
    chk("i_addr", out_addr, 64'h0);
    step();
    chk("i_drained", out_valid, 0);
    chk("i_addr_next", out_addr, 64'h4);

    // ---- S then B back to back
    do_reset();
    drv(3'b001, 64'd8, 7'b0100011, 5'd0, 3'd3, 5'd2, 5'd7, 7'd0);
    step();
    drv(3'b010, -64'sd8, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0);
    step();
    in_valid = 1'b0;
    chk("s_word", instruction, 32'h00713423);
    chk("s_addr", out_addr, 64'h0);
    step();
    chk("b_valid", out_valid, 1);
    chk("b_word", instruction, 32'hFE208CE3);
    chk("b_addr", out_addr, 64'h4);
    step();
    chk("sb_drained", out_valid, 0);

    // ---- range errors: I 2048, B odd, then good I
    do_reset();
    drv(3'b000, 64'd2048, 7'b0010011, 5'd5, 3'd0, 5'd6, 5'd0, 7'd0);
    step();
    drv(3'b010, 64'd5, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0);
    step();
    chk("err1_pulse", range_err, 1);
    chk("err1_count", err_count, 1);
    chk("err1_no_out", out_valid, 0);
    drv(3'b000, 64'd0, 7'b0010011, 5'd5, 3'd0, 5'd6, 5'd0, 7'd0);
    step();
    in_valid = 1'b0;
    chk("err2_pulse", range_err, 1);
    chk("err2_count", err_count, 2);
    chk("err2_no_out", out_valid, 0);
    step();
    chk("err_pulse_clear", range_err, 0);
    chk("err_good_valid", out_valid, 1);
    chk("err_good_word", instruction, 32'h00030293);
    chk("err_good_addr", out_addr, 64'h0);
    chk("err_count_hold", err_count, 2);
    step();

    // ---- backpressure: 5 stalled cycles, 3 I-types offered
    do_reset();
    out_ready = 1'b0;
    drv(3'b000, 64'd0, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0);
    step();
    drv(3'b000, 64'd0, 7'b0010011, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0);
    step();
    drv(3'b000, 64'd0, 7'b0010011, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0);
    chk("bp_in_ready_lo", in_ready, 0);
    chk("bp_word0", instruction, 32'h00000093);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_word", instruction, 32'h00000093);
      chk("bp_hold_addr", out_addr, 64'h0);
      chk("bp_hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_word1", instruction, 32'h00000113);
    chk("bp_addr1", out_addr, 64'h4);
    step();
    chk("bp_word2", instruction, 32'h00000193);
    chk("bp_addr2", out_addr, 64'h8);
    step();
    chk("bp_drained", out_valid, 0);
    chk("bp_addr_end", out_addr, 64'hC);

    // ---- reset with both stages full, then R-type at BASE_ADDR
    out_ready = 1'b0;
    drv(3'b000, 64'd0, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0);
    step();
    step();
    chk("mid_full_ready", in_ready, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_addr", out_addr, 64'h0);
    step();
    chk("mid_rst_empty", out_valid, 0);
    drv(3'b011, 64'd0, 7'b0110011, 5'd1, 3'd0, 5'd2, 5'd3, 7'b0100000);
    step();
    in_valid = 1'b0;
    step();
    chk("r_word", instruction, 32'h403100B3);
    chk("r_addr", out_addr, 64'h0);
    step();

    // ---- boundary immediates and invalid type
    do_reset();
    drv(3'b000, -64'sd2048, 7'b0010011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0);
    step();
    drv(3'b010, 64'd4094, 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0);
    step();
    drv(3'b101, 64'd0, 7'b0010011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0);
    chk("bnd_i_min", instruction, 32'h80000013);
    chk("bnd_i_addr", out_addr, 64'h0);
    step();
    in_valid = 1'b0;
    chk("bnd_b_max", instruction, 32'h7E000FE3);
    chk("bnd_b_addr", out_addr, 64'h4);
    step();
    chk("bnd_bad_type_err", range_err, 1);
    chk("bnd_bad_type_cnt", err_count, 1);
    chk("bnd_bad_type_noout", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Pipelined instruction encoder, the inverse of immediate extraction.
- Takes decoded fields plus a 64-bit sign-extended immediate, range-checks the immediate, and packs an RV64 32-bit instruction word.
- Emits each word with a sequential instruction-memory address over a valid/ready stream.
- Used by the program loader and the self-checking benches to build instruction memory images.

Parameters:
- BASE_ADDR, 64'h0, address tagged on the first emitted instruction after reset.
- ADDR_STEP, 4, address increment per emitted instruction.
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  input fields valid
- in_ready  output  1  encoder can accept this cycle
- imm_type  input  3  000=I, 001=S, 010=B, 011=R (no immediate); others invalid
- immediate  input  64  sign-extended immediate
- opcode  input  7  instr[6:0]
- rd  input  5  destination register
- funct3  input  3  funct3 field
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- funct7  input  7  used for R only
- out_valid  output  1  instruction word valid
- out_ready  input  1  consumer accepts
- instruction  output  32  encoded word
- out_addr  output  64  memory address of the presented word
- range_err  output  1  one-cycle pulse when an entry is dropped
- err_count  output  ERR_CNT_W  saturating count of dropped entries

Behaviour:
- Reset values: out_valid=0, instruction=0, out_addr=BASE_ADDR, range_err=0, err_count=0, both stages empty.
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset asserted mid-operation discards all in-flight entries.
- Pipeline structure: S1 latches the fields and computes an ok flag; S2 is the output register.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - Output consumed when out_valid && out_ready.
  - Latency is 2 cycles: accept at edge N gives out_valid high after edge N+1.
- Stage advance rules:
  - s1_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s1_adv (purely combinational; no dependence on in_valid).
  - Full throughput of 1 word per cycle when out_ready=1.
- Range check in S1:
  - I/S: immediate[63:11] all equal to immediate[11], i.e. -2048..2047.
  - B: immediate[63:12] all equal and immediate[0]=0, i.e. -4096..4094, even only.
  - R: always ok.
  - Invalid imm_type: not ok.
- Failed entry on s1_adv: it is dropped and never reaches S2.
  - range_err=1 for exactly that cycle.
  - err_count increments, saturating at all-ones.
  - out_addr is not advanced.
- Packing (all fields taken from S1, written into S2 on an ok s1_adv):
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
- Address:
  - out_addr is registered and equals the address of the word currently in S2.
  - It advances by ADDR_STEP on each output handshake, wrapping modulo 2^64.
- Backpressure: while out_valid && !out_ready, instruction and out_addr hold stable. At most 2 entries are in flight.
- Simultaneous output handshake and S1 advance in the same cycle: S2 is reloaded with no bubble, and out_addr advances once.
- Round-trip property: I/S/B immediate extraction applied to the emitted word returns the original immediate for every ok entry.

Test Plan:
- Reset → out_valid=0, in_ready=1, out_addr=0, err_count=0, range_err=0.
- I (opcode 0010011, rd=5, rs1=6, funct3=0, imm=-1), out_ready=1 → instruction=0xFFF30293, out_addr=0, out_valid 2 cycles after accept.
- S (opcode 0100011, funct3=3, rs1=2, rs2=7, imm=8), then B (opcode 1100011, funct3=0, rs1=1, rs2=2, imm=-8), back to back → 0x00713423 @ addr 0, then 0xFE208CE3 @ addr 4, on consecutive cycles.
- I with imm=2048, then B with imm=5, then valid I with imm=0 → two range_err pulses, err_count=2, only the last word emitted, at addr 0.
- out_ready=0 for 5 cycles while 3 I-types are offered → in_ready=0 after 2 accepts and outputs held stable; release gives 3 words in order at addrs 0, 4, 8.
- Reset asserted with both stages full → next cycle out_valid=0; the next word emitted is at addr BASE_ADDR.
